gat_layer_scheduler: RTL
========================

Name: gat_layer_scheduler

Overview:
- Top-level sequencer for one GAT layer pass (conv1 or conv2).
- Gates the start on the BRAM load-done flags, issues a one-cycle start pulse to the datapath, and counts per-subgraph completions up to NUM_SUBGRAPHS.
- Raises gat_ready when the pass finishes, and runs a stall watchdog while the pass is in progress.
- Sits between the register bank (start/layer/ready/debug) and gat_top's datapath controls.

Parameters:
- TOP_WIDTH, 32, width of the debug words.
- NUM_SUBGRAPHS, 2708, subgraph completions per layer pass (must be ≥1).
- TIMEOUT_W, 24, watchdog counter width; timeout fires after 2^TIMEOUT_W − 1 idle RUN cycles.
- CNT_W, $clog2(NUM_SUBGRAPHS+1), subgraph counter width (localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- gat_start  in  1  start request pulse; level is sampled each cycle.
- gat_layer  in  1  0 = conv1, 1 = conv2; captured when gat_start is accepted.
- gat_abort  in  1  abort request; returns the block to IDLE.
- h_data_bram_load_done  in  1  level.
- h_node_info_bram_load_done  in  1  level.
- wgt_bram_load_done  in  1  level.
- subgraph_done  in  1  one-cycle pulse from the aggregator per finished subgraph.
- layer_start  out  1  one-cycle start pulse to the datapath.
- layer_sel  out  1  latched layer selection.
- gat_busy  out  1  high in WAIT_LOAD, START, RUN.
- gat_ready  out  1  pass complete.
- gat_error  out  1  watchdog tripped.
- gat_debug_1  out  TOP_WIDTH  {zero-pad, spurious_flag, layer_sel, state[2:0]}.
- gat_debug_2  out  TOP_WIDTH  zero-extended subgraph count.
- gat_debug_3  out  TOP_WIDTH  cycle count of the current or last pass, saturating.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state IDLE, all counters 0, spurious_flag 0.
- State encoding: IDLE=0, WAIT_LOAD=1, START=2, RUN=3, DONE=4, ERR=5.
- IDLE:
  - gat_start=1 → WAIT_LOAD.
  - Latch layer_sel ← gat_layer.
  - Clear subgraph count, cycle count, watchdog and spurious_flag.
- DONE: gat_start=1 does the same as IDLE and also clears gat_ready on the same edge.
- WAIT_LOAD → START when the load condition is met (evaluated combinationally that cycle):
  - Always required: h_node_info_bram_load_done & wgt_bram_load_done.
  - Also required when layer_sel=0: h_data_bram_load_done.
  - When layer_sel=1, h_data_bram_load_done is ignored, because conv2 input comes from the conv1 feature BRAM.
- START: layer_start=1 for exactly this one cycle → RUN.
- RUN:
  - Each subgraph_done increments the count.
  - subgraph_done while count = NUM_SUBGRAPHS−1 → DONE, count = NUM_SUBGRAPHS, gat_ready=1.
  - Watchdog clears on every subgraph_done and otherwise increments.
  - Watchdog reaching all-ones → ERR, gat_error=1.
  - If completion and timeout occur in the same cycle, completion wins.
- DONE: gat_ready holds 1 until the next accepted gat_start or gat_abort.
- ERR: gat_error holds 1. Only gat_abort or rst leaves ERR; gat_start is ignored.
- gat_abort (any state except IDLE) → IDLE next edge:
  - Clears gat_ready, gat_error, gat_busy.
  - Counters are retained for debug.
  - Abort has priority over gat_start, subgraph_done and timeout in the same cycle.
- gat_start in WAIT_LOAD, START, RUN or ERR: ignored, with no side effects.
- subgraph_done outside RUN: not counted; sets spurious_flag (sticky until the next accepted start).
- Cycle counter: increments every cycle in WAIT_LOAD, START and RUN; saturates at all-ones; frozen in DONE, ERR and IDLE.
- Latency with load flags already high:
  - start accepted at edge N → WAIT_LOAD at N+1.
  - layer_start high in cycle N+2.
  - RUN from N+3.
  - gat_ready high the cycle after the final subgraph_done edge.
- rst mid-pass: returns to reset values on the next edge; layer_start never glitches.

Test Plan:
- Reset, then idle 10 cycles → all outputs 0, gat_debug_1=0.
- NUM_SUBGRAPHS=4, layer 0, all loads high, start pulse; 4 subgraph_done pulses 5 cycles apart:
  - layer_start high exactly 2 cycles after start is sampled.
  - gat_ready=1 one cycle after the 4th pulse.
  - gat_debug_2=4, gat_busy=0.
- Layer 1 with h_data_bram_load_done=0 and the other two loads high → proceeds to START. Same stimulus with layer 0 → stays in WAIT_LOAD (debug state=1) until h_data is raised.
- TIMEOUT_W=4, RUN with no subgraph_done:
  - gat_error=1 after 15 RUN cycles, state=5.
  - gat_start ignored while in ERR.
  - gat_abort → IDLE, gat_error=0.
- Mid-RUN, count=2: assert gat_abort together with subgraph_done → IDLE, count stays 2. A subgraph_done pulse in IDLE sets debug bit 4 and leaves count=2.
- In DONE, gat_start with gat_layer=1 → gat_ready=0 next cycle, layer_sel=1, count=0, and a new pass completes normally.

Source files
------------

// File: rtl/gat_layer_scheduler.sv
// gat_layer_scheduler: sequences one GAT layer pass from load-gated start to subgraph-count completion, with watchdog.
module gat_layer_scheduler #(
  parameter int TOP_WIDTH     = 32,
  parameter int NUM_SUBGRAPHS = 2708,
  parameter int TIMEOUT_W     = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gat_start,
  input  logic                 gat_layer,
  input  logic                 gat_abort,
  input  logic                 h_data_bram_load_done,
  input  logic                 h_node_info_bram_load_done,
  input  logic                 wgt_bram_load_done,
  input  logic                 subgraph_done,
  output logic                 layer_start,
  output logic                 layer_sel,
  output logic                 gat_busy,
  output logic                 gat_ready,
  output logic                 gat_error,
  output logic [TOP_WIDTH-1:0] gat_debug_1,
  output logic [TOP_WIDTH-1:0] gat_debug_2,
  output logic [TOP_WIDTH-1:0] gat_debug_3
);
  localparam int CNT_W = $clog2(NUM_SUBGRAPHS + 1);
  typedef enum logic [2:0] {IDLE, WAIT_LOAD, START, RUN, DONE, ERR} state_t;
  state_t               state_q, state_d;
  logic                 layer_q, layer_d, spur_q, spur_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic [TOP_WIDTH-1:0] cyc_q, cyc_d;
  logic                 ls_q, busy_q, ready_q, error_q;
  logic                 accept, abort, load_ok, last, active;
  assign accept  = gat_start && (state_q == IDLE || state_q == DONE);
  assign abort   = gat_abort && state_q != IDLE;
  // conv2 reads the conv1 feature BRAM, so the h_data load only gates conv1
  assign load_ok = h_node_info_bram_load_done && wgt_bram_load_done && (layer_q || h_data_bram_load_done);
  assign last    = subgraph_done && cnt_q == CNT_W'(NUM_SUBGRAPHS - 1);
  assign active  = state_q == WAIT_LOAD || state_q == START || state_q == RUN;
  assign wd_inc  = wd_q + 1'b1;
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    cyc_d   = cyc_q;
    spur_d  = spur_q;
    if (abort) state_d = IDLE;
    else if (accept) begin
      state_d = WAIT_LOAD;
      layer_d = gat_layer;
      cnt_d   = '0;
      wd_d    = '0;
      cyc_d   = '0;
      spur_d  = 1'b0;
    end else begin
      spur_d = spur_q || (subgraph_done && state_q != RUN);
      cyc_d  = (active && !(&cyc_q)) ? cyc_q + 1'b1 : cyc_q;
      case (state_q)
        WAIT_LOAD: state_d = load_ok ? START : WAIT_LOAD;
        START:     state_d = RUN;
        RUN: begin
          cnt_d   = subgraph_done ? cnt_q + 1'b1 : cnt_q;
          wd_d    = subgraph_done ? '0 : wd_inc;
          // completion beats a timeout landing on the same cycle
          state_d = last ? DONE : (!subgraph_done && &wd_inc) ? ERR : RUN;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      layer_q <= 1'b0;
      spur_q  <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
      cyc_q   <= '0;
      ls_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      spur_q  <= spur_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      cyc_q   <= cyc_d;
      ls_q    <= state_d == START;
      busy_q  <= state_d == WAIT_LOAD || state_d == START || state_d == RUN;
      ready_q <= state_d == DONE;
      error_q <= state_d == ERR;
    end
  end
  assign layer_start = ls_q;
  assign layer_sel   = layer_q;
  assign gat_busy    = busy_q;
  assign gat_ready   = ready_q;
  assign gat_error   = error_q;
  assign gat_debug_1 = TOP_WIDTH'({spur_q, layer_q, state_q});
  assign gat_debug_2 = TOP_WIDTH'(cnt_q);
  assign gat_debug_3 = cyc_q;
endmodule
